// File: rtl/fetch_ctrl_pkg.sv
// Shared front-end types for the rvga core.
// Holds the machine word type, the PC-mux select encoding produced by EX
// and the fetch sequencer state encoding. This file has no ports.
package rvga_types;

    typedef logic [31:0] rvga_word;

    // EX branch/jump resolution: pc4 keeps sequential fetch, jmp takes jmp_tgt.
    typedef enum logic {
        pcmux_pc4 = 1'b0,
        pcmux_jmp = 1'b1
    } pcmux_selop;

    // S_REQ: presenting (or ready to present) a request.
    // S_WAIT: one request granted, waiting for its response.
    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state;

    localparam rvga_word PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_ctrl_buf.sv
// One-entry valid/ready register slice between fetch and decode.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr_i               synchronous clear (redirect), wins over everything
//   load_i              capture pc_i/instr_i and mark the entry valid
//   pc_i, instr_i       entry payload
//   ready_i             downstream accepts the entry this cycle
//   valid_o, pc_o, instr_o  entry state toward decode
// The payload registers change only on load, so the outputs are stable
// while the entry waits for ready.
module fetch_buf
    import rvga_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr_i,
    input  logic     load_i,
    input  rvga_word pc_i,
    input  rvga_word instr_i,
    input  logic     ready_i,
    output logic     valid_o,
    output rvga_word pc_o,
    output rvga_word instr_o
);

    logic     valid_q, valid_d;
    rvga_word pc_q, pc_d;
    rvga_word instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            // A load in the same cycle as a drain replaces the drained entry.
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the architectural PC, issues one
// request at a time to instruction memory, discards wrong-path responses
// after a redirect and hands fetched instructions to decode via fetch_buf.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   ex_valid, pcmux_sel, jmp_tgt       EX branch/jump resolution
//   imem_req/addr/gnt/rvalid/rdata     instruction memory port
//   if_valid/pc/instr, if_ready        buffered instruction toward decode
//   flush                              kill younger stages (combinational)
//   misalign                           one-cycle pulse after a misaligned jump
//   redirect_cnt                       number of taken redirects, wraps
module fetch_ctrl
    import rvga_types::*;
#(
    parameter rvga_word RESET_PC = 32'h0000_0000,
    parameter int       CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  pcmux_selop       pcmux_sel,
    input  rvga_word         jmp_tgt,
    output logic             imem_req,
    output rvga_word         imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  rvga_word         imem_rdata,
    output logic             if_valid,
    output rvga_word         if_pc,
    output rvga_word         if_instr,
    input  logic             if_ready,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    fetch_state       state_q, state_d;
    rvga_word         pc_q, pc_d;
    logic             drop_q, drop_d;
    logic             misalign_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic redirect, bad, granted, load;

    // Only word-aligned targets redirect; a target with bit 1 set is
    // reported and otherwise ignored. Bit 0 alone is neither.
    assign redirect = ex_valid && (pcmux_sel == pcmux_jmp) && (jmp_tgt[1:0] == 2'b00);
    assign bad      = ex_valid && (pcmux_sel == pcmux_jmp) && jmp_tgt[1];

    // Gating with rst_n keeps the memory port and flush quiet while in reset.
    assign imem_req  = rst_n && (state_q == S_REQ) && (!if_valid || if_ready);
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign flush     = rst_n && redirect;
    assign granted   = imem_req && imem_gnt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        load    = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_REQ: begin
                if (granted) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            pc_d  = jmp_tgt;
            load  = 1'b0;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            // Any request already in flight (or granted right now) is wrong-path.
            if (state_q == S_WAIT) begin
                drop_d = !imem_rvalid;
            end else if (granted) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            misalign_q <= bad;
            cnt_q      <= cnt_d;
        end
    end

    assign misalign     = misalign_q;
    assign redirect_cnt = cnt_q;

    fetch_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (redirect),
        .load_i  (load),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .ready_i (if_ready),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .instr_o (if_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    import rvga_types::*;

    localparam rvga_word RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    pcmux_selop  pcmux_sel = pcmux_pc4;
    rvga_word    jmp_tgt = '0;
    logic        imem_req;
    rvga_word    imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    rvga_word    imem_rdata = '0;
    logic        if_valid;
    rvga_word    if_pc;
    rvga_word    if_instr;
    logic        if_ready = 1'b0;
    logic        flush;
    logic        misalign;
    logic [31:0] redirect_cnt;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pcmux_sel(pcmux_sel),
        .jmp_tgt(jmp_tgt), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush), .misalign(misalign), .redirect_cnt(redirect_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endtask

    function automatic rvga_word instr_of(input rvga_word a);
        return a ^ 32'hA5C3_0013;
    endfunction

    // ---------------- memory responder + scoreboard ----------------
    logic       gnt_en = 1'b0;
    logic       rdy_en = 1'b0;
    int         lat = 1;
    logic       pend_v = 1'b0;
    int         pend_cnt = 0;
    rvga_word   pend_addr = '0;
    rvga_word   pc_exp = RST_PC;
    logic [63:0] sbq[$];
    logic       hold_v = 1'b0;
    rvga_word   hold_pc = '0;
    rvga_word   hold_instr = '0;

    task automatic tick();
        logic        granted;
        rvga_word    g_addr;
        logic [63:0] e;
        granted = 1'b0;
        g_addr  = '0;
        @(negedge clk);
        ex_valid    = 1'b0;
        pcmux_sel   = pcmux_pc4;
        imem_gnt    = gnt_en;
        if_ready    = rdy_en;
        imem_rvalid = pend_v && (pend_cnt == 1);
        imem_rdata  = imem_rvalid ? instr_of(pend_addr) : 32'h0;
        #1;
        if (hold_v) begin
            chk("hold_valid", if_valid, 1'b1);
            chk("hold_pc", if_pc, hold_pc);
            chk("hold_instr", if_instr, hold_instr);
        end
        if (if_valid && !if_ready) chk("req_while_full", imem_req, 1'b0);
        if (if_valid && if_ready) begin
            if (sbq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_underflow: got handshake pc %h expected none", if_pc);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", if_pc, e[63:32]);
                chk("sb_instr", if_instr, e[31:0]);
            end
        end
        if (imem_req && imem_gnt) begin
            chk("imem_addr", imem_addr, pc_exp);
            sbq.push_back({pc_exp, instr_of(pc_exp)});
            pc_exp  = pc_exp + 32'd4;
            granted = 1'b1;
            g_addr  = imem_addr;
        end
        hold_v     = if_valid && !if_ready;
        hold_pc    = if_pc;
        hold_instr = if_instr;
        @(posedge clk);
        if (imem_rvalid) pend_v = 1'b0;
        else if (pend_v) pend_cnt--;
        if (granted) begin
            pend_v    = 1'b1;
            pend_cnt  = lat;
            pend_addr = g_addr;
        end
    endtask

    task automatic drain();
        gnt_en = 1'b0;
        rdy_en = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("sb_empty", sbq.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        ex_valid    = 1'b1;          // redirect request must not flush in reset
        pcmux_sel   = pcmux_jmp;
        jmp_tgt     = 32'h0000_0700;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        if_ready    = 1'b1;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_ifv", if_valid, 1'b0);
        chk("rst_mis", misalign, 1'b0);
        chk("rst_cnt", redirect_cnt, 32'd0);
        @(negedge clk);
        ex_valid  = 1'b0;
        pcmux_sel = pcmux_pc4;
        imem_gnt  = 1'b0;
        rst_n     = 1'b1;
        pend_v    = 1'b0;
        sbq.delete();
        pc_exp    = RST_PC;
        hold_v    = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       exv;
        pcmux_selop sel;
        rvga_word   tgt;
        logic       gnt, rv;
        rvga_word   rdata;
        logic       rdy;
        logic       e_req;
        rvga_word   e_addr;
        logic       e_flush, e_mis, e_ifv;
        rvga_word   e_pc, e_instr;
        int         e_cnt;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic exv, input pcmux_selop sel, input rvga_word tgt,
                                input logic gnt, input logic rv, input rvga_word rdata,
                                input logic rdy, input logic e_req, input rvga_word e_addr,
                                input logic e_flush, input logic e_mis, input logic e_ifv,
                                input rvga_word e_pc, input rvga_word e_instr, input int e_cnt);
        vec_t v;
        v.exv = exv; v.sel = sel; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_flush = e_flush;
        v.e_mis = e_mis; v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic apply_vec(input int i);
        vec_t v;
        v = tbl[i];
        @(negedge clk);
        ex_valid = v.exv; pcmux_sel = v.sel; jmp_tgt = v.tgt;
        imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata; if_ready = v.rdy;
        #1;
        chk($sformatf("v%0d_req", i), imem_req, v.e_req);
        if (v.e_req) chk($sformatf("v%0d_addr", i), imem_addr, v.e_addr);
        chk($sformatf("v%0d_flush", i), flush, v.e_flush);
        chk($sformatf("v%0d_mis", i), misalign, v.e_mis);
        chk($sformatf("v%0d_ifv", i), if_valid, v.e_ifv);
        if (v.e_ifv) begin
            chk($sformatf("v%0d_ifpc", i), if_pc, v.e_pc);
            chk($sformatf("v%0d_ifinstr", i), if_instr, v.e_instr);
        end
        chk($sformatf("v%0d_cnt", i), redirect_cnt, v.e_cnt);
        @(posedge clk);
    endtask

    initial begin
        //               exv sel        tgt          g  rv rdata         rdy  req addr        fl mis ifv pc          instr         cnt
        tbl[0]  = mk(0, pcmux_pc4, 32'h0,       1, 0, 32'h0,        1,   1, 32'h000,     0, 0, 0, 32'h0,     32'h0,        0);
        tbl[1]  = mk(0, pcmux_pc4, 32'h0,       0, 1, 32'h1111_0000,1,   0, 32'h0,       0, 0, 0, 32'h0,     32'h0,        0);
        tbl[2]  = mk(0, pcmux_pc4, 32'h0,       1, 0, 32'h0,        1,   1, 32'h004,     0, 0, 1, 32'h000,   32'h1111_0000,0);
        tbl[3]  = mk(1, pcmux_jmp, 32'h100,     0, 0, 32'h0,        1,   0, 32'h0,       1, 0, 0, 32'h0,     32'h0,        0);
        tbl[4]  = mk(0, pcmux_pc4, 32'h0,       0, 1, 32'h2222_0000,1,   0, 32'h0,       0, 0, 0, 32'h0,     32'h0,        1);
        tbl[5]  = mk(0, pcmux_pc4, 32'h0,       1, 0, 32'h0,        1,   1, 32'h100,     0, 0, 0, 32'h0,     32'h0,        1);
        tbl[6]  = mk(1, pcmux_jmp, 32'h200,     0, 1, 32'h3333_0000,1,   0, 32'h0,       1, 0, 0, 32'h0,     32'h0,        1);
        tbl[7]  = mk(0, pcmux_pc4, 32'h0,       0, 0, 32'h0,        1,   1, 32'h200,     0, 0, 0, 32'h0,     32'h0,        2);
        tbl[8]  = mk(0, pcmux_pc4, 32'h0,       1, 0, 32'h0,        1,   1, 32'h200,     0, 0, 0, 32'h0,     32'h0,        2);
        tbl[9]  = mk(0, pcmux_pc4, 32'h0,       0, 1, 32'h4444_0000,1,   0, 32'h0,       0, 0, 0, 32'h0,     32'h0,        2);
        tbl[10] = mk(1, pcmux_jmp, 32'h102,     0, 0, 32'h0,        0,   0, 32'h0,       0, 0, 1, 32'h200,   32'h4444_0000,2);
        tbl[11] = mk(0, pcmux_pc4, 32'h0,       0, 0, 32'h0,        0,   0, 32'h0,       0, 1, 1, 32'h200,   32'h4444_0000,2);
        tbl[12] = mk(0, pcmux_pc4, 32'h0,       1, 0, 32'h0,        1,   1, 32'h204,     0, 0, 1, 32'h200,   32'h4444_0000,2);
        tbl[13] = mk(0, pcmux_pc4, 32'h0,       0, 1, 32'h5555_0000,1,   0, 32'h0,       0, 0, 0, 32'h0,     32'h0,        2);
        tbl[14] = mk(1, pcmux_jmp, 32'h300,     1, 0, 32'h0,        1,   1, 32'h208,     1, 0, 1, 32'h204,   32'h5555_0000,2);
        tbl[15] = mk(0, pcmux_pc4, 32'h0,       0, 1, 32'h6666_0000,1,   0, 32'h0,       0, 0, 0, 32'h0,     32'h0,        3);
        tbl[16] = mk(0, pcmux_pc4, 32'h0,       1, 0, 32'h0,        1,   1, 32'h300,     0, 0, 0, 32'h0,     32'h0,        3);
        tbl[17] = mk(0, pcmux_pc4, 32'h0,       0, 1, 32'h7777_0000,0,   0, 32'h0,       0, 0, 0, 32'h0,     32'h0,        3);
        tbl[18] = mk(1, pcmux_pc4, 32'h400,     0, 0, 32'h0,        0,   0, 32'h0,       0, 0, 1, 32'h300,   32'h7777_0000,3);
        tbl[19] = mk(1, pcmux_jmp, 32'h401,     0, 0, 32'h0,        0,   0, 32'h0,       0, 0, 1, 32'h300,   32'h7777_0000,3);
        tbl[20] = mk(1, pcmux_jmp, 32'h500,     0, 0, 32'h0,        0,   0, 32'h0,       1, 0, 1, 32'h300,   32'h7777_0000,3);
        tbl[21] = mk(0, pcmux_pc4, 32'h0,       0, 0, 32'h0,        0,   1, 32'h500,     0, 0, 0, 32'h0,     32'h0,        4);

        // Sequential streaming with back-to-back responses.
        do_reset();
        gnt_en = 1'b1; rdy_en = 1'b1; lat = 1;
        for (int k = 0; k < 14; k++) tick();
        drain();

        // Decode stalls after the first fetch, then resumes.
        do_reset();
        gnt_en = 1'b1; rdy_en = 1'b0; lat = 1;
        for (int k = 0; k < 6; k++) tick();
        rdy_en = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        drain();

        // Slower memory with random decode back-pressure.
        do_reset();
        gnt_en = 1'b1; lat = 2;
        for (int k = 0; k < 30; k++) begin
            rdy_en = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // Redirect / misalign corner cases.
        do_reset();
        for (int i = 0; i < 22; i++) apply_vec(i);

        // Asynchronous reset while waiting for a response.
        @(negedge clk);
        ex_valid = 1'b1; pcmux_sel = pcmux_jmp; jmp_tgt = 32'h102;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; if_ready = 1'b1;
        #1;
        chk("ar_req", imem_req, 1'b1);
        chk("ar_addr", imem_addr, 32'h500);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0; imem_gnt = 1'b0;
        #1;
        chk("ar_mis_pre", misalign, 1'b1);
        chk("ar_cnt_pre", redirect_cnt, 32'd4);
        chk("ar_req_wait", imem_req, 1'b0);
        #1;
        rst_n = 1'b0;
        ex_valid = 1'b1; pcmux_sel = pcmux_jmp; jmp_tgt = 32'h600;
        #1;
        chk("ar_req", imem_req, 1'b0);
        chk("ar_flush", flush, 1'b0);
        chk("ar_mis", misalign, 1'b0);
        chk("ar_ifv", if_valid, 1'b0);
        chk("ar_cnt", redirect_cnt, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0; pcmux_sel = pcmux_pc4; rst_n = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b1;
        #1;
        chk("ar_first_req", imem_req, 1'b1);
        chk("ar_first_addr", imem_addr, RST_PC);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
